// File: rtl/traffic_sensor_conditioner_if.sv
// Raw detector inputs and conditioned demand/stuck outputs of the sensor conditioner.
interface traffic_sensor_conditioner_if;
  logic       ew_str_raw;
  logic       ew_left_raw;
  logic       ns_raw;
  logic       clear_stuck;
  logic       s_s;
  logic       l_s;
  logic       n_s;
  logic [2:0] stuck;

  modport master (
    output ew_str_raw, ew_left_raw, ns_raw, clear_stuck,
    input  s_s, l_s, n_s, stuck
  );

  modport slave (
    input  ew_str_raw, ew_left_raw, ns_raw, clear_stuck,
    output s_s, l_s, n_s, stuck
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Three independent debounce/hold channels with stuck-detector recall and sticky stuck flags.
module traffic_sensor_conditioner #(
  parameter int unsigned DEB_CYC   = 3,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned STUCK_CYC = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  traffic_sensor_conditioner_if.slave   sif
);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    RISE  = 3'd1,
    ON    = 3'd2,
    FALL  = 3'd3,
    STUCK = 3'd4
  } state_t;

  logic [2:0] raw;
  logic [2:0] dem;
  logic [2:0] stuck_set;
  logic [2:0] stuck_q;

  // Bit order: 2 = E-W through, 1 = E-W left, 0 = N-S.
  assign raw       = {sif.ew_str_raw, sif.ew_left_raw, sif.ns_raw};
  assign sif.s_s   = dem[2];
  assign sif.l_s   = dem[1];
  assign sif.n_s   = dem[0];
  assign sif.stuck = stuck_q;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_t     state_q, state_d;
    logic [3:0] deb_q, deb_d;
    logic [7:0] run_q, run_d;
    logic       dem_q;
    logic       hit;

    always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      run_d   = raw[g] ? ((run_q == 8'hFF) ? run_q : run_q + 8'd1) : '0;
      hit     = (run_d == 8'(STUCK_CYC)) && (state_q inside {RISE, ON, FALL});
      case (state_q)
        OFF: begin
          deb_d = '0;
          if (raw[g]) begin
            if (DEB_CYC == 1) state_d = ON;
            else begin
              state_d = RISE;
              deb_d   = 4'd1;
            end
          end
        end
        RISE: begin
          if (!raw[g]) begin
            state_d = OFF;
            deb_d   = '0;
          end else if (deb_q + 4'd1 == 4'(DEB_CYC)) begin
            state_d = ON;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
        ON, STUCK: begin
          if (!raw[g]) begin
            if (HOLD_CYC == 1) begin
              state_d = OFF;
              deb_d   = '0;
            end else begin
              state_d = FALL;
              deb_d   = 4'd1;
            end
          end
        end
        FALL: begin
          if (raw[g]) begin
            state_d = ON;
            deb_d   = '0;
          end else if (deb_q + 4'd1 == 4'(HOLD_CYC)) begin
            state_d = OFF;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
        default: begin
          state_d = OFF;
          deb_d   = '0;
        end
      endcase
      // Stuck detection overrides the normal debounce transition on the same edge.
      if (hit) begin
        state_d = STUCK;
        deb_d   = '0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= OFF;
        deb_q   <= '0;
        run_q   <= '0;
        dem_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        deb_q   <= deb_d;
        run_q   <= run_d;
        dem_q   <= state_d inside {ON, FALL, STUCK};
      end
    end

    assign dem[g]       = dem_q;
    assign stuck_set[g] = hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stuck_q <= '0;
    else        stuck_q <= stuck_set | (stuck_q & ~{3{sif.clear_stuck}});
  end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed and randomized checks of the sensor conditioner against a run-length reference model.
module tb_traffic_sensor_conditioner;

  localparam int unsigned DEB   = 3;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned STUCK = 16;

  logic clk;
  logic reset;

  traffic_sensor_conditioner_if sif ();

  traffic_sensor_conditioner #(
    .DEB_CYC   (DEB),
    .HOLD_CYC  (HOLD),
    .STUCK_CYC (STUCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model: consecutive high/low run lengths per channel.
  int unsigned hr [3];
  int unsigned lr [3];
  logic [2:0]  m_out;
  logic [2:0]  m_stuck;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] dem_vec();
    return {sif.s_s, sif.l_s, sif.n_s};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      hr[c] = 0;
      lr[c] = 0;
    end
    m_out   = '0;
    m_stuck = '0;
  endtask

  // Drive raws {str,left,ns} and clear_stuck, clock once, update model, compare.
  task automatic step(input logic [2:0] r, input logic clr, input string tag);
    logic [2:0] set;
    sif.ew_str_raw  = r[2];
    sif.ew_left_raw = r[1];
    sif.ns_raw      = r[0];
    sif.clear_stuck = clr;
    @(posedge clk);
    set = '0;
    for (int c = 0; c < 3; c++) begin
      if (r[c]) begin
        if (hr[c] < 255) hr[c]++;
        lr[c] = 0;
      end else begin
        hr[c] = 0;
        lr[c]++;
      end
      if (!m_out[c] && hr[c] >= DEB)      m_out[c] = 1'b1;
      else if (m_out[c] && lr[c] >= HOLD) m_out[c] = 1'b0;
      set[c] = (hr[c] == STUCK);
    end
    m_stuck = set | (m_stuck & ~{3{clr}});
    #1;
    chk({tag, "_dem"}, dem_vec(), m_out);
    chk({tag, "_stuck"}, sif.stuck, m_stuck);
  endtask

  initial begin
    logic [2:0] lvl;
    int unsigned p;

    reset = 1'b0;
    sif.ew_str_raw  = 1'b0;
    sif.ew_left_raw = 1'b0;
    sif.ns_raw      = 1'b0;
    sif.clear_stuck = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dem", dem_vec(), 3'b000);
    chk("reset_stuck", sif.stuck, 3'b000);
    #1 reset = 1'b1;

    // Short N-S glitch never asserts.
    repeat (2) begin
      step(3'b001, 1'b0, "glitch");
      chk("glitch_ns", {2'b00, sif.n_s}, 3'b000);
    end
    repeat (4) begin
      step(3'b000, 1'b0, "glitch_low");
      chk("glitch_ns_low", {2'b00, sif.n_s}, 3'b000);
    end

    // Left-turn assert after 3rd high, deassert after 4th low.
    step(3'b010, 1'b0, "left_h1");
    step(3'b010, 1'b0, "left_h2");
    chk("left_h2_l", {2'b00, sif.l_s}, 3'b000);
    step(3'b010, 1'b0, "left_h3");
    chk("left_h3_l", {2'b00, sif.l_s}, 3'b001);
    step(3'b010, 1'b0, "left_h4");
    for (int i = 1; i <= 4; i++) begin
      step(3'b000, 1'b0, "left_low");
      chk("left_low_l", {2'b00, sif.l_s}, (i < 4) ? 3'b001 : 3'b000);
    end

    // Low gap shorter than hold never drops.
    repeat (4) step(3'b010, 1'b0, "gap_on");
    repeat (3) begin
      step(3'b000, 1'b0, "gap_low");
      chk("gap_l", {2'b00, sif.l_s}, 3'b001);
    end
    repeat (2) begin
      step(3'b010, 1'b0, "gap_high");
      chk("gap_l2", {2'b00, sif.l_s}, 3'b001);
    end
    repeat (4) step(3'b000, 1'b0, "gap_off");

    // Simultaneous rise, then E-W through stuck.
    step(3'b111, 1'b0, "all_1");
    step(3'b111, 1'b0, "all_2");
    chk("all_2_dem", dem_vec(), 3'b000);
    step(3'b111, 1'b0, "all_3");
    chk("all_3_dem", dem_vec(), 3'b111);
    for (int i = 4; i <= 16; i++) begin
      step(3'b100, 1'b0, "str_run");
      chk("str_run_stuck", sif.stuck, (i < 16) ? 3'b000 : 3'b100);
    end
    chk("str_stuck_s", {2'b00, sif.s_s}, 3'b001);
    repeat (3) step(3'b100, 1'b0, "str_stuck_hold");
    for (int i = 1; i <= 4; i++) begin
      step(3'b000, 1'b0, "str_fall");
      chk("str_fall_s", {2'b00, sif.s_s}, (i < 4) ? 3'b001 : 3'b000);
    end
    repeat (3) step(3'b000, 1'b0, "str_idle");
    chk("str_sticky", sif.stuck, 3'b100);
    step(3'b000, 1'b1, "clear");
    chk("clear_stuck", sif.stuck, 3'b000);

    // Clear on the same edge as N-S stuck detection: set wins.
    for (int i = 1; i <= 16; i++)
      step({(i >= 10), 1'b0, 1'b1}, (i == 16), "ns_run");
    chk("set_wins", sif.stuck, 3'b001);
    chk("pre_reset_s", {2'b00, sif.s_s}, 3'b001);

    // Asynchronous reset mid-cycle.
    #2 reset = 1'b0;
    sif.ns_raw = 1'b0;
    #1;
    model_reset();
    chk("async_dem", dem_vec(), 3'b000);
    chk("async_stuck", sif.stuck, 3'b000);
    @(posedge clk);
    #2 reset = 1'b1;
    step(3'b100, 1'b0, "rel_1");
    step(3'b100, 1'b0, "rel_2");
    chk("rel_2_s", {2'b00, sif.s_s}, 3'b000);
    step(3'b100, 1'b0, "rel_3");
    chk("rel_3_s", {2'b00, sif.s_s}, 3'b001);

    // Randomized phases: glitchy, moderate, long runs.
    lvl = 3'b100;
    for (int i = 0; i < 600; i++) begin
      p = (i < 200) ? 35 : (i < 400) ? 10 : 2;
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 99) < p) lvl[c] = ~lvl[c];
      step(lvl, ($urandom_range(0, 29) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
